// File: rtl/alib_ram_pkg.sv
// Shared constants, state encoding and helpers for the alib simple-dual-port RAM.
// No logic: pure types and elaboration-time functions.
// No flow control.
package alib_ram_pkg;

    localparam string RAM_STYLE_BLOCK = "block";
    localparam string RAM_STYLE_ULTRA = "ultra";

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    function automatic int alib_addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/alib_ram_init_ctrl.sv
// Post-reset clear sequencer: walks every address writing zero, then raises init_done.
// Latency: DEPTH cycles after reset release (1 cycle when clearing is disabled).
// No backpressure: the clear port always wins over user writes while it runs.
module alib_ram_init_ctrl
    import alib_ram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = alib_addr_width(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam bit                    DO_CLEAR  = (CLEAR_ON_RESET != 0);

    init_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // The last zero write and the hand-over to READY share one edge.
                    if (!DO_CLEAR || (r_cnt == LAST_ADDR)) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    r_state     <= ST_READY;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we    = DO_CLEAR && (r_state == ST_INIT);
    assign clr_addr  = r_cnt;
    assign init_done = r_init_done;

endmodule

// File: rtl/alib_ram_sdp.sv
// Simple-dual-port RAM with byte enables, selectable collision mode and hardware clear.
// Latency: read data and rd_valid READ_LATENCY cycles after rd_en; writes land in 1 cycle.
// No backpressure: one read and one write accepted per cycle once init_done is high.
module alib_ram_sdp
    import alib_ram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 16,
    parameter int    DEPTH          = 1024,
    parameter int    BYTE_WIDTH     = 8,
    parameter string RAM_STYLE      = RAM_STYLE_BLOCK,
    parameter int    READ_LATENCY   = 1,
    parameter int    WRITE_FIRST    = COLL_READ_FIRST,
    parameter int    CLEAR_ON_RESET = 1,
    parameter int    ADDR_WIDTH     = alib_addr_width(DEPTH),
    parameter int    NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_done
);

    localparam bit ADDR_FULL = (DEPTH == (1 << ADDR_WIDTH));
    localparam bit BYPASS    = (WRITE_FIRST == COLL_WRITE_FIRST);

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_err_byte
            $error("alib_ram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if ((READ_LATENCY < READ_LATENCY_MIN) || (READ_LATENCY > READ_LATENCY_MAX)) begin : g_err_lat
            $error("alib_ram_sdp: READ_LATENCY must be in 1..4");
        end
        if (DEPTH < 2) begin : g_err_depth
            $error("alib_ram_sdp: DEPTH must be at least 2");
        end
        if ((RAM_STYLE != RAM_STYLE_BLOCK) && (RAM_STYLE != RAM_STYLE_ULTRA)) begin : g_err_style
            $error("alib_ram_sdp: RAM_STYLE must be block or ultra");
        end
    endgenerate

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_init_done;

    alib_ram_init_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr),
        .init_done (w_init_done)
    );

    logic w_wr_in_rng;
    logic w_rd_in_rng;

    generate
        if (ADDR_FULL) begin : g_addr_full
            assign w_wr_in_rng = 1'b1;
            assign w_rd_in_rng = 1'b1;
        end else begin : g_addr_part
            localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
            assign w_wr_in_rng = (wr_addr <= LAST_ADDR);
            assign w_rd_in_rng = (rd_addr <= LAST_ADDR);
        end
    endgenerate

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_collide;

    assign w_wr_acc  = wr_en && w_init_done && w_wr_in_rng;
    assign w_rd_acc  = rd_en && w_init_done;
    assign w_collide = BYPASS && w_wr_acc && w_rd_in_rng && (rd_addr == wr_addr);

    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Unreset array read register keeps the read path mappable onto RAM output flops.
    logic [DATA_WIDTH-1:0] r_rd_raw;

    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_rd_raw <= r_mem[rd_addr];
        end
    end

    // Reset sets r_s1_zero so the stage-1 word reads as 0 until the first read lands.
    logic                  r_s1_zero;
    logic [NUM_BYTES-1:0]  r_s1_byp;
    logic [DATA_WIDTH-1:0] r_s1_wdat;
    logic [DATA_WIDTH-1:0] w_s1_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_zero <= 1'b1;
            r_s1_byp  <= '0;
            r_s1_wdat <= '0;
        end else if (w_rd_acc) begin
            r_s1_zero <= !w_rd_in_rng;
            r_s1_byp  <= w_collide ? wr_be : '0;
            r_s1_wdat <= wr_data;
        end
    end

    always_comb begin
        w_s1_dat = r_rd_raw;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_s1_byp[i]) begin
                w_s1_dat[i*BYTE_WIDTH +: BYTE_WIDTH] = r_s1_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (r_s1_zero) begin
            w_s1_dat = '0;
        end
    end

    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   w_stg_dat [READ_LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign w_stg_dat[0] = w_s1_dat;

    // Each output stage only loads when the stage before it carries a fresh word.
    generate
        for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stg
            logic [DATA_WIDTH-1:0] r_dat;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dat <= '0;
                end else if (r_vld[k-1]) begin
                    r_dat <= w_stg_dat[k-1];
                end
            end
            assign w_stg_dat[k] = r_dat;
        end
    endgenerate

    assign rd_data   = w_stg_dat[READ_LATENCY-1];
    assign rd_valid  = r_vld[READ_LATENCY-1];
    assign init_done = w_init_done;

endmodule

// File: tb/tb_alib_ram_sdp.sv
// Scoreboard bench: two RAM instances (write-first/ultra/latency 3 and read-first/block/latency 1)
// share one randomized stimulus stream and are checked against an array model.
module tb_alib_ram_sdp;

    localparam int DW    = 16;
    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int NB    = 2;
    localparam int RL_A  = 3;
    localparam int RL_B  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [NB-1:0] wr_be = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          a_rd_valid, b_rd_valid, a_init_done, b_init_done;

    always #5 clk = ~clk;

    alib_ram_sdp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .RAM_STYLE("ultra"),
        .READ_LATENCY(RL_A), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .init_done(a_init_done)
    );

    alib_ram_sdp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .RAM_STYLE("block"),
        .READ_LATENCY(RL_B), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .init_done(b_init_done)
    );

    typedef struct {
        logic [DW-1:0] dat;
        int            stamp;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    exp_t          ea, eb;
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            mdl_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, update the model, return just after the rising edge.
    task automatic cyc_step(input bit we, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit re, input logic [AW-1:0] ra);
        exp_t          e;
        logic [DW-1:0] old_w, new_w;
        @(negedge clk);
        wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        if (mdl_ready) begin
            if (re) begin
                old_w = (int'(ra) < DEPTH) ? mdl[ra] : '0;
                new_w = old_w;
                if (we && (ra == wa) && (int'(ra) < DEPTH))
                    for (int b = 0; b < NB; b++) if (be[b]) new_w[b*8 +: 8] = wd[b*8 +: 8];
                e.stamp = cyc;
                e.dat = new_w; qa.push_back(e);
                e.dat = old_w; qb.push_back(e);
            end
            if (we && (int'(wa) < DEPTH))
                for (int b = 0; b < NB; b++) if (be[b]) mdl[wa][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rand_step(input bit live);
        logic [AW-1:0] wa;
        wa = AW'($urandom);
        cyc_step(1'($urandom_range(0, 1)), NB'($urandom), wa, DW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? wa : AW'($urandom));
        if (!live) mdl_ready = 1'b0;
    endtask

    // Called just after a rising edge; counts rising edges until init_done while hammering ignored ports.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        mdl_ready = 1'b0;
        while (!a_init_done && (n < DEPTH + 20)) begin
            rand_step(1'b0);
            n++;
        end
        check({name, "_clear_cycles"}, n, DEPTH);
        check({name, "_b_init_done"}, {31'b0, b_init_done}, 1);
        mdl_ready = 1'b1;
    endtask

    task automatic do_reset(input string name);
        #2 rst = 1'b0;
        #1;
        check({name, "_a_valid_drop"}, {31'b0, a_rd_valid}, 0);
        check({name, "_b_valid_drop"}, {31'b0, b_rd_valid}, 0);
        check({name, "_init_drop"}, {31'b0, a_init_done}, 0);
        qa.delete();
        qb.delete();
        mdl_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        idle(3);
        rst = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents rd_valid; otherwise output must hold.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (a_rd_valid) begin
                if (qa.size() == 0) check("a_unexpected_valid", {31'b0, a_rd_valid}, 0);
                else begin
                    ea = qa.pop_front();
                    check("a_rd_data", a_rd_data, ea.dat);
                    check("a_latency", cyc, ea.stamp + RL_A);
                    last_a = ea.dat;
                end
            end else begin
                check("a_hold", a_rd_data, last_a);
                if ((qa.size() != 0) && (qa[0].stamp + RL_A <= cyc)) begin
                    check("a_missing_valid", {31'b0, a_rd_valid}, 1);
                    void'(qa.pop_front());
                end
            end
            if (b_rd_valid) begin
                if (qb.size() == 0) check("b_unexpected_valid", {31'b0, b_rd_valid}, 0);
                else begin
                    eb = qb.pop_front();
                    check("b_rd_data", b_rd_data, eb.dat);
                    check("b_latency", cyc, eb.stamp + RL_B);
                    last_b = eb.dat;
                end
            end else begin
                check("b_hold", b_rd_data, last_b);
                if ((qb.size() != 0) && (qb[0].stamp + RL_B <= cyc)) begin
                    check("b_missing_valid", {31'b0, b_rd_valid}, 1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_rd_data", a_rd_data, 0);
        check("rst_a_rd_valid", {31'b0, a_rd_valid}, 0);
        check("rst_a_init_done", {31'b0, a_init_done}, 0);
        check("rst_b_rd_data", b_rd_data, 0);
        check("rst_b_rd_valid", {31'b0, b_rd_valid}, 0);
        check("rst_b_init_done", {31'b0, b_init_done}, 0);

        rst = 1'b1;
        wait_init("boot");
        for (int i = 0; i < 64; i++) cyc_step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(4);

        // 0xBEEF @5 single read; 0x1234 then lane-0 0xABCD @2 -> 0x12CD; collision on @7.
        cyc_step(1'b1, 2'b11, 6'd5, 16'hBEEF, 1'b0, '0);
        cyc_step(1'b0, '0, '0, '0, 1'b1, 6'd5);
        idle(4);
        cyc_step(1'b1, 2'b11, 6'd2, 16'h1234, 1'b0, '0);
        cyc_step(1'b1, 2'b01, 6'd2, 16'hABCD, 1'b0, '0);
        cyc_step(1'b1, 2'b00, 6'd2, 16'h5555, 1'b1, 6'd2);
        cyc_step(1'b1, 2'b11, 6'd7, 16'h0001, 1'b0, '0);
        cyc_step(1'b1, 2'b11, 6'd7, 16'h00FF, 1'b1, 6'd7);
        cyc_step(1'b0, '0, '0, '0, 1'b1, 6'd7);
        idle(4);

        for (int i = 0; i < 400; i++) rand_step(1'b1);
        for (int i = 0; i < 64; i++) cyc_step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(RL_A + 2);

        cyc_step(1'b0, '0, '0, '0, 1'b1, 6'd5);
        cyc_step(1'b0, '0, '0, '0, 1'b1, 6'd2);
        do_reset("midread");
        wait_init("midread");

        for (int i = 0; i < 20; i++) rand_step(1'b1);
        do_reset("preclear");
        for (int i = 0; i < 9; i++) rand_step(1'b0);
        do_reset("midclear");
        wait_init("midclear");

        for (int i = 0; i < DEPTH; i++) cyc_step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        for (int i = 0; i < 100; i++) rand_step(1'b1);
        idle(RL_A + 3);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alib_ram_sdp.md
# alib_ram_sdp

Parametrised simple-dual-port RAM for the range-image library: one write port and one read port on a single clock. It generalises the per-style BRAM/URAM wrappers with:
- selectable RAM style;
- byte-granular write enables;
- configurable read latency with a `rd_valid` strobe;
- defined read/write collision behaviour;
- a hardware memory-clear sequencer, so URAM and BRAM contents are deterministic after every reset.

It sits between the range-image projection writers and the downstream neighbourhood readers.

## Interface
Parameters:
- DATA_WIDTH, 16: word width in bits; must be a multiple of BYTE_WIDTH.
- DEPTH, 1024: number of words; ≥ 2.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RAM_STYLE, "block": "block" or "ultra"; forwarded to the array's ram_style attribute.
- READ_LATENCY, 1: cycles from accepted `rd_en` to `rd_valid`; legal range 1..4.
- WRITE_FIRST, 0: 0 = read-first collision, 1 = write-first collision.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after each reset release.
- ADDR_WIDTH, derived: $clog2(DEPTH).

Ports:
- clk  in  1  — single clock.
- rst  in  1  — asynchronous active-low reset.
- wr_en  in  1  — write request.
- wr_be  in  NUM_BYTES  — per-lane write enable.
- wr_addr  in  ADDR_WIDTH  — write address.
- wr_data  in  DATA_WIDTH  — write data.
- rd_en  in  1  — read request.
- rd_addr  in  ADDR_WIDTH  — read address.
- rd_data  out  DATA_WIDTH  — read data.
- rd_valid  out  1  — rd_data carries the result of a read.
- init_done  out  1  — high when the array is usable.

## Operation
State machine:
- States are INIT and READY.
- rst low forces INIT and resets the clear counter to 0.
- INIT with CLEAR_ON_RESET=1:
  - Writes zero to address cnt on every cycle, incrementing cnt.
  - Leaves INIT for READY after writing address DEPTH-1.
- INIT with CLEAR_ON_RESET=0: goes to READY on the first clock after rst deasserts.
- READY is held until the next reset.

Behaviour in INIT:
- wr_en and rd_en are ignored; no user write reaches the array.
- No read is launched and rd_valid stays 0.

Write (READY):
- When wr_en=1, each lane i with wr_be[i]=1 updates bits [i*BYTE_WIDTH +: BYTE_WIDTH] at wr_addr on the clock edge.
- Lanes with wr_be[i]=0 keep their contents.
- wr_be=0 with wr_en=1 is a no-op.

Read (READY):
- When rd_en=1, the read is accepted on that edge.
- The word is fetched in stage 1 and shifted through READ_LATENCY-1 output registers.

Collision (rd_en and wr_en both 1, rd_addr == wr_addr, same cycle):
- WRITE_FIRST=0: the read returns the old word.
- WRITE_FIRST=1: the read returns the old word with the enabled lanes replaced by wr_data (bypass merge).
- A write in cycle t is always visible to a read accepted in cycle t+1 or later.

Outputs:
- rd_data holds its last value when no new read completes.
- rd_valid is a 1-cycle strobe per accepted read; back-to-back reads give a continuous rd_valid.
- Out-of-range addresses (addr ≥ DEPTH when DEPTH is not a power of two): writes are dropped, reads return 0 with rd_valid=1.

Reset values: rd_data=0, rd_valid=0, init_done=0, all pipeline valid bits 0. The array itself is not reset; the clear sequence handles it.

## Timing
- Read latency: rd_en accepted at edge t gives rd_data and rd_valid at edge t+READ_LATENCY. Throughput is 1 read per cycle.
- Write latency: 1 cycle.
- Clear duration: init_done rises DEPTH cycles after the first rising edge with rst high when CLEAR_ON_RESET=1, and after 1 cycle when CLEAR_ON_RESET=0.
- rst low mid-read: in-flight reads are discarded and rd_valid drops asynchronously.
- rst low mid-clear: the clear restarts at address 0 after release.
- rd_en or wr_en asserted in the same cycle init_done first reads 1 is accepted.

## Structure
- Package alib_ram_pkg holds:
  - RAM_STYLE string constants;
  - the collision-mode constants;
  - function alib_addr_width(depth), which returns max(1, $clog2(depth));
  - the INIT/READY state encoding typedef.
- Sub-module alib_ram_init_ctrl implements the clear FSM and counter and outputs clr_we, clr_addr and init_done.
- The top level muxes the clear port against the user write port and holds the array and read pipeline.
- Elaboration-time checks on DATA_WIDTH % BYTE_WIDTH and on the READ_LATENCY range.

## Test plan
- Clear after reset: DEPTH=16, CLEAR_ON_RESET=1; release rst → init_done=1 exactly 16 cycles later; reads of addresses 0..15 all return 0x0000.
- Read latency: READ_LATENCY=3; write 0xBEEF to address 5, then pulse rd_en at address 5 at cycle t → rd_valid=1 and rd_data=0xBEEF at t+3 only.
- Byte enables: address 2 holds 0x1234; write 0xABCD with wr_be=2'b01 → a later read of address 2 returns 0x12CD.
- Collision: address 7 holds 0x0001; same-cycle write 0x00FF and read of address 7 → 0x0001 when WRITE_FIRST=0, 0x00FF when WRITE_FIRST=1.
- Reset mid-operation: assert rst low with 2 reads in flight and clear at cnt=9 → rd_valid=0 immediately, neither read completes, and the clear restarts at 0 with init_done taking a full DEPTH cycles.
- Streaming: URAM style, rd_en held high for 64 cycles over addresses 0..63 → 64 consecutive rd_valid cycles with data in address order.
